frame_rx: RTL and testbench

FRAME_RX -- requirements
Module: frame_rx

---
 rtl/frame_rx.sv | 190 +++++++++++++++++++
 tb/tb_frame_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : frame_rx
// Purpose  : Mid-bit-sampling serial frame receiver with a valid/ready output
//            register and sticky overrun flag. FRAME_RX_PARITY_EN adds one
//            even-parity bit after the data bits.
// Revision : 1.0 - initial release
// ============================================================================
module frame_rx #(
    parameter int DATA_W  = 8,
    parameter int BIT_DIV = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init,
    input  logic              rxd,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              frm_err,
    output logic              par_err,
    output logic              ovr_err
);

    localparam int c_DIV_W = $clog2(BIT_DIV);
    localparam int c_CNT_W = $clog2(DATA_W + 1);
    localparam logic [c_DIV_W-1:0] c_DIV_HALF = c_DIV_W'(BIT_DIV / 2 - 1);
    localparam logic [c_DIV_W-1:0] c_DIV_FULL = c_DIV_W'(BIT_DIV - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [c_DIV_W-1:0]  r_div;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0]   r_shift;
    logic                r_init_s;
    logic                r_init_prev;
    logic [DATA_W-1:0]   r_out_data;
    logic                r_out_valid;
    logic                r_frm_err;
    logic                r_ovr_err;
    logic                w_init_rise;
    logic                w_tick;
    logic                w_load;
    logic                w_hs;

    assign w_init_rise = r_init_s & ~r_init_prev;
    assign w_tick      = (r_state != S_IDLE) && (r_div == '0);
    assign w_load      = (r_state == S_STOP) && w_tick;
    assign w_hs        = r_out_valid & out_ready;

    // Upstream start detector is captured on the falling edge.
    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            r_init_s <= 1'b0;
        end else begin
            r_init_s <= init;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_init_rise) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    w_next = rxd ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (w_tick && (r_cnt == c_CNT_LAST)) begin
`ifdef FRAME_RX_PARITY_EN
                    w_next = S_PARITY;
`else
                    w_next = S_STOP;
`endif
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_init_prev <= 1'b0;
            r_div       <= '0;
            r_cnt       <= '0;
            r_shift     <= '0;
        end else begin
            r_init_prev <= r_init_s;
            if (r_state == S_IDLE) begin
                if (w_init_rise) begin
                    r_div <= c_DIV_HALF;
                    r_cnt <= '0;
                end
            end else begin
                r_div <= w_tick ? c_DIV_FULL : r_div - 1'b1;
            end
            if ((r_state == S_DATA) && w_tick) begin
                r_shift <= {rxd, r_shift[DATA_W-1:1]};
                r_cnt   <= r_cnt + 1'b1;
            end
        end
    end

    // A load always wins over a coincident handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out_data  <= '0;
            r_out_valid <= 1'b0;
            r_frm_err   <= 1'b0;
            r_ovr_err   <= 1'b0;
        end else begin
            if (w_load) begin
                r_out_data  <= r_shift;
                r_frm_err   <= ~rxd;
                r_out_valid <= 1'b1;
                if (r_out_valid && !out_ready) begin
                    r_ovr_err <= 1'b1;
                end
            end else if (w_hs) begin
                r_out_valid <= 1'b0;
                r_ovr_err   <= 1'b0;
            end
        end
    end

`ifdef FRAME_RX_PARITY_EN
    logic r_par_bad;
    logic r_par_err;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_par_bad <= 1'b0;
            r_par_err <= 1'b0;
        end else begin
            if ((r_state == S_PARITY) && w_tick) begin
                r_par_bad <= ^{r_shift, rxd};
            end
            if (w_load) begin
                r_par_err <= r_par_bad;
            end
        end
    end

    assign par_err = r_par_err;
`else
    assign par_err = 1'b0;
`endif

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign frm_err   = r_frm_err;
    assign ovr_err   = r_ovr_err;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_frame_rx.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_frame_rx
// Purpose  : Directed scoreboard bench for frame_rx (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_rx;

    localparam int DATA_W  = 8;
    localparam int BIT_DIV = 16;
`ifdef FRAME_RX_PARITY_EN
    localparam int NBITS = DATA_W + 3;
`else
    localparam int NBITS = DATA_W + 2;
`endif
    // Posedge index (counted from the init drive) at which the stop bit loads.
    localparam int LOAD_N = 1 + BIT_DIV / 2 + (NBITS - 1) * BIT_DIV;
    localparam int ABORT_N = 1 + BIT_DIV / 2 + 4 * BIT_DIV + 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              init;
    logic              rxd;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              busy;
    logic              frm_err;
    logic              par_err;
    logic              ovr_err;
`ifdef FRAME_RX_PARITY_EN
    logic              par_flip = 1'b0;
`endif

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              frm;
        logic              par;
        logic              ovr;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    frame_rx #(.DATA_W(DATA_W), .BIT_DIV(BIT_DIV)) dut (
        .clk       (clk),
        .reset     (reset),
        .init      (init),
        .rxd       (rxd),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frm_err   (frm_err),
        .par_err   (par_err),
        .ovr_err   (ovr_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    function automatic exp_t mk(input logic [DATA_W-1:0] d, input logic f,
                                input logic p, input logic o);
        mk = {d, f, p, o};
    endfunction

    function automatic logic [15:0] frame_bits(input logic [DATA_W-1:0] d, input logic stop);
`ifdef FRAME_RX_PARITY_EN
        frame_bits = {5'b0, stop, (^d) ^ par_flip, d, 1'b0};
`else
        frame_bits = {6'b0, stop, d, 1'b0};
`endif
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, "_data"},  32'(out_data), 0);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_busy"},  32'(busy), 0);
        chk({tag, "_frm"},   32'(frm_err), 0);
        chk({tag, "_par"},   32'(par_err), 0);
        chk({tag, "_ovr"},   32'(ovr_err), 0);
    endtask

    // Call just after a rising edge. Bit k is held for BIT_DIV cycles; a
    // second init pulse mid-frame must be ignored by the receiver.
    task automatic send(input logic [DATA_W-1:0] d, input logic stop,
                        input logic pre_valid, input logic hs_at_load, input int abort_at);
        logic [15:0] bits;
        exp_t        e;
        int          n;
        bits = frame_bits(d, stop);
        for (int k = 0; k < NBITS; k++) begin
            for (int c = 0; c < BIT_DIV; c++) begin
                if (c == 0) rxd = bits[k];
                if ((k == 0 || k == 2) && c == 0) init = 1'b1;
                if ((k == 0 || k == 2) && c == 3) init = 1'b0;
                @(posedge clk); #1;
                n = k * BIT_DIV + c + 1;
                if (n == abort_at) begin
                    reset = 1'b1;
                    #1;
                    chk_all_zero("rst_mid");
                    @(posedge clk); #1;
                    reset = 1'b0;
                    rxd   = 1'b1;
                    return;
                end
                if (n == BIT_DIV / 2) chk("busy_start", 32'(busy), 1);
                if (n == LOAD_N - 1) begin
                    chk("valid_pre", 32'(out_valid), 32'(pre_valid));
                    chk("busy_pre", 32'(busy), 1);
                    if (hs_at_load) out_ready = 1'b1;
                end
                if (n == LOAD_N) begin
                    if (hs_at_load) out_ready = 1'b0;
                    chk("sb_level", 32'(sb.size() != 0), 1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("valid_load", 32'(out_valid), 1);
                        chk("data_load",  32'(out_data), 32'(e.data));
                        chk("frm_load",   32'(frm_err), 32'(e.frm));
                        chk("par_load",   32'(par_err), 32'(e.par));
                        chk("ovr_load",   32'(ovr_err), 32'(e.ovr));
                        chk("busy_load",  32'(busy), 0);
                    end
                end
            end
        end
        rxd = 1'b1;
    endtask

    initial begin
        reset     = 1'b1;
        init      = 1'b0;
        rxd       = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        // Clean frame, consumer ready: one-cycle valid pulse at the load edge.
        sb.push_back(mk(8'hA5, 1'b0, 1'b0, 1'b0));
        send(8'hA5, 1'b1, 1'b0, 1'b0, 0);
        chk("clean_valid_after", 32'(out_valid), 0);
        chk("clean_data_hold", 32'(out_data), 32'hA5);
        chk("clean_busy_after", 32'(busy), 0);

        // False start: line stays high through the start-bit sample.
        init = 1'b1;
        rxd  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        init = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("false_busy_before", 32'(busy), 1);
        @(posedge clk); #1;
        chk("false_busy_after", 32'(busy), 0);
        repeat (10) @(posedge clk);
        #1;
        chk("false_valid", 32'(out_valid), 0);
        chk("false_data", 32'(out_data), 32'hA5);

        // Framing error: stop bit low.
        sb.push_back(mk(8'h3C, 1'b1, 1'b0, 1'b0));
        send(8'h3C, 1'b0, 1'b0, 1'b0, 0);
        chk("frm_hold", 32'(frm_err), 1);

        // Overrun, then one handshake clears valid and the sticky flag.
        out_ready = 1'b0;
        sb.push_back(mk(8'h11, 1'b0, 1'b0, 1'b0));
        send(8'h11, 1'b1, 1'b0, 1'b0, 0);
        sb.push_back(mk(8'h22, 1'b0, 1'b0, 1'b1));
        send(8'h22, 1'b1, 1'b1, 1'b0, 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("ovr_hs_valid", 32'(out_valid), 0);
        chk("ovr_hs_ovr", 32'(ovr_err), 0);
        chk("ovr_hs_data", 32'(out_data), 32'h22);

        // Handshake coinciding with a load: new frame wins, no overrun.
        sb.push_back(mk(8'h44, 1'b0, 1'b0, 1'b0));
        send(8'h44, 1'b1, 1'b0, 1'b0, 0);
        sb.push_back(mk(8'h55, 1'b0, 1'b0, 1'b0));
        send(8'h55, 1'b1, 1'b1, 1'b1, 0);
        chk("coin_valid", 32'(out_valid), 1);
        chk("coin_ovr", 32'(ovr_err), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("coin_clear", 32'(out_valid), 0);

`ifdef FRAME_RX_PARITY_EN
        par_flip = 1'b1;
        sb.push_back(mk(8'h07, 1'b0, 1'b1, 1'b0));
        send(8'h07, 1'b1, 1'b0, 1'b0, 0);
        par_flip = 1'b0;
        sb.push_back(mk(8'h07, 1'b0, 1'b0, 1'b0));
        send(8'h07, 1'b1, 1'b0, 1'b0, 0);
`endif

        // Leave valid, data and overrun set, then reset after 4 data bits.
        out_ready = 1'b0;
        sb.push_back(mk(8'h66, 1'b0, 1'b0, 1'b0));
        send(8'h66, 1'b1, 1'b0, 1'b0, 0);
        sb.push_back(mk(8'h77, 1'b0, 1'b0, 1'b1));
        send(8'h77, 1'b1, 1'b1, 1'b0, 0);
        send(8'h88, 1'b1, 1'b1, 1'b0, ABORT_N);
        repeat (4) @(posedge clk);
        #1;
        chk("rst_idle_busy", 32'(busy), 0);

        out_ready = 1'b1;
        sb.push_back(mk(8'h5A, 1'b0, 1'b0, 1'b0));
        send(8'h5A, 1'b1, 1'b0, 1'b0, 0);
        chk("post_rst_valid", 32'(out_valid), 0);
        chk("post_rst_data", 32'(out_data), 32'h5A);
        chk("sb_drained", 32'(sb.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
